fft_io_buffer: RTL

//  Parametrised, buffered successor to the single-register FFT I/O port.

---
 rtl/fft_io_buffer_pkg.sv | 21 ++
 rtl/fft_io_buffer_fifo.sv | 57 +++++
 rtl/fft_io_buffer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fft_io_buffer_pkg.sv
// Shared defaults and types for the FFT I/O buffer.
// Optional error flags are enabled by defining FFT_IO_ERR_FLAGS_EN.
`ifndef FFT_DATA_WIDTH
`define FFT_DATA_WIDTH 16
`endif
`ifndef FFT_IO_DEPTH
`define FFT_IO_DEPTH 8
`endif

package fft_io_buffer_pkg;

  localparam int FFT_DATA_WIDTH_DEF = `FFT_DATA_WIDTH;
  localparam int FFT_IO_DEPTH_DEF   = `FFT_IO_DEPTH;

  // Direction of the external bus as seen from this block.
  typedef enum logic {
    BUS_RX = 1'b0,
    BUS_TX = 1'b1
  } bus_dir_e;

endpackage

// File: rtl/fft_io_buffer_fifo.sv
// Synchronous first-word-fall-through FIFO used for both RX and TX paths.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module fft_io_fifo #(
  parameter int  DATA_WIDTH = 16,
  parameter int  DEPTH      = 8,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  io_clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_W:0]       level
);

  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_W:0]       wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]       rd_ptr_q, rd_ptr_d;
  logic                  wr_en;
  logic                  rd_en;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign level = wr_ptr_q - rd_ptr_q;
  assign rdata = mem_q[rd_ptr_q[ADDR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge io_clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge io_clock) begin
    if (wr_en) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/fft_io_buffer.sv
// Buffered bridge between a tristated external bus and the FFT core (RX and TX FIFOs).
// Define FFT_IO_ERR_FLAGS_EN to add sticky rx_overflow / tx_underflow flags and err_clear.
module fft_io_buffer
  import fft_io_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = FFT_DATA_WIDTH_DEF,
  parameter int DEPTH      = FFT_IO_DEPTH_DEF,
  parameter int LVL_W      = $clog2(DEPTH) + 1
) (
  input  logic                  io_clock,
  input  logic                  reset,
`ifdef FFT_IO_ERR_FLAGS_EN
  input  logic                  err_clear,
  output logic                  rx_overflow,
  output logic                  tx_underflow,
`endif
  inout  wire  [DATA_WIDTH-1:0] ext_bidir_port,
  input  logic                  ext_cs,
  input  logic                  ext_we,
  output logic                  ext_tx_valid,
  output logic                  ext_rx_full,
  output logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_valid,
  input  logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_valid,
  output logic                  out_ready,
  output logic [LVL_W-1:0]      rx_level,
  output logic [LVL_W-1:0]      tx_level
);

  bus_dir_e              dir_q, dir_d;
  logic [DATA_WIDTH-1:0] tx_out_q, tx_out_d;
  logic                  rx_full, rx_empty, rx_push, rx_pop, rx_push_req;
  logic                  tx_full, tx_empty, tx_push, tx_pop;
  logic [DATA_WIDTH-1:0] tx_rdata;

  // Handshakes: a core transfer happens on an edge where valid and ready are both high.
  assign rx_pop      = in_valid && in_ready;
  assign tx_push     = out_valid && out_ready;
  // The bus is still ours for one cycle after a pop, so RX sampling waits it out.
  assign rx_push_req = ext_cs && !ext_we && (dir_q == BUS_RX);
  assign rx_push     = rx_push_req && (!rx_full || rx_pop);
  assign tx_pop      = ext_cs && ext_we && !tx_empty;

  always_comb begin
    dir_d    = BUS_RX;
    tx_out_d = tx_out_q;
    if (tx_pop) begin
      dir_d    = BUS_TX;
      tx_out_d = tx_rdata;
    end
  end

  always_ff @(posedge io_clock or posedge reset) begin
    if (reset) begin
      dir_q    <= BUS_RX;
      tx_out_q <= '0;
    end else begin
      dir_q    <= dir_d;
      tx_out_q <= tx_out_d;
    end
  end

  assign ext_bidir_port = (dir_q == BUS_TX) ? tx_out_q : {DATA_WIDTH{1'bz}};
  assign ext_tx_valid   = (dir_q == BUS_TX);
  assign ext_rx_full    = rx_full;
  assign in_valid       = !rx_empty;
  assign out_ready      = !tx_full;

  fft_io_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_rx_fifo (
    .io_clock (io_clock),
    .reset    (reset),
    .push     (rx_push),
    .pop      (rx_pop),
    .wdata    (ext_bidir_port),
    .rdata    (in_data),
    .full     (rx_full),
    .empty    (rx_empty),
    .level    (rx_level)
  );

  fft_io_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_tx_fifo (
    .io_clock (io_clock),
    .reset    (reset),
    .push     (tx_push),
    .pop      (tx_pop),
    .wdata    (out_data),
    .rdata    (tx_rdata),
    .full     (tx_full),
    .empty    (tx_empty),
    .level    (tx_level)
  );

`ifdef FFT_IO_ERR_FLAGS_EN
  logic rx_ovf_q, rx_ovf_d, tx_unf_q, tx_unf_d;
  logic rx_drop, tx_unf_evt;

  assign rx_drop    = rx_push_req && rx_full && !rx_pop;
  assign tx_unf_evt = ext_cs && ext_we && tx_empty;

  // Sticky flags; a new event in the clearing cycle keeps the flag set.
  always_comb begin
    rx_ovf_d = rx_ovf_q;
    tx_unf_d = tx_unf_q;
    if (err_clear) begin
      rx_ovf_d = 1'b0;
      tx_unf_d = 1'b0;
    end
    if (rx_drop)    rx_ovf_d = 1'b1;
    if (tx_unf_evt) tx_unf_d = 1'b1;
  end

  always_ff @(posedge io_clock or posedge reset) begin
    if (reset) begin
      rx_ovf_q <= 1'b0;
      tx_unf_q <= 1'b0;
    end else begin
      rx_ovf_q <= rx_ovf_d;
      tx_unf_q <= tx_unf_d;
    end
  end

  assign rx_overflow  = rx_ovf_q;
  assign tx_underflow = tx_unf_q;
`endif

endmodule
